pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Generic parametrised inter-stage pipeline register for the RV32IM pipeline (IF/ID, ID/EX, EX/MA, MA/WB).
- Replaces the fixed-field, always-load stage registers.
- Adds a valid/ready handshake for stalls, a synchronous flush for branch/jump squash, and bubble insertion that zeroes control fields.
- Optionally adds a 2-entry skid buffer so IN_READY is registered, which breaks the ready path between stages.

Parameters:
DATA_W, 69, payload width (PC, rd address, ALU data, etc.), not cleared on bubble
CTRL_W, 7, control width (MR, MW, W_REG, REG_EN, etc.), forced to 0 whenever the stage holds a bubble
SKID, 1, 1 = 2-entry skid buffer with registered IN_READY; 0 = single register with combinational IN_READY

Ports:
CLK  input  1  clock, rising edge
RESET_N  input  1  asynchronous active-low reset
FLUSH  input  1  synchronous squash of all held entries
IN_VALID  input  1  upstream stage has a valid instruction
IN_READY  output  1  this stage accepts one entry this cycle
IN_DATA  input  DATA_W  upstream payload
IN_CTRL  input  CTRL_W  upstream control bits
OUT_VALID  output  1  output entry is valid
OUT_READY  input  1  downstream stage consumes the output entry
OUT_DATA  output  DATA_W  held payload
OUT_CTRL  output  CTRL_W  held control; 0 when OUT_VALID=0
OCC  output  2  entries held (0..2; max 1 when SKID=0)

Behaviour:
- Transfer rules: accept = IN_VALID & IN_READY; consume = OUT_VALID & OUT_READY. Both are evaluated at the rising edge of CLK.
- Reset (RESET_N=0, asynchronous, any time including mid-transfer):
  - OUT_VALID=0, OUT_DATA=0, OUT_CTRL=0, OCC=0.
  - Skid register cleared.
  - IN_READY=1 (SKID=1); for SKID=0, IN_READY=1 follows from the ready equation.
  - Normal operation resumes on the first rising edge after deassertion.
- Latency: one cycle IN→OUT when the stage is empty. Throughput is one entry per cycle while OUT_READY=1.
- SKID=1 state machine (state encoded by main-valid and skid-valid):
  - EMPTY (OCC=0): accept → FULL, main<=IN.
  - FULL (OCC=1):
    - accept & consume → FULL, main<=IN.
    - accept & !consume → SKID, skid<=IN.
    - !accept & consume → EMPTY.
    - Otherwise hold.
  - SKID (OCC=2): IN_READY=0. consume → FULL, main<=skid. Otherwise hold.
  - IN_READY is a register equal to !(next state == SKID). It never depends combinationally on OUT_READY.
- SKID=0:
  - IN_READY = !OUT_VALID | OUT_READY (combinational).
  - accept → main<=IN.
  - consume & !accept → EMPTY.
  - OCC never exceeds 1.
- Bubble:
  - Whenever the next state is EMPTY, OUT_CTRL is loaded with 0.
  - OUT_DATA retains its last value (don't-care for the checker, but must not be X after reset).
- Ordering: strict FIFO. An entry in skid always leaves after the entry in main. No entry is ever duplicated or dropped, except on FLUSH.
- FLUSH (synchronous, highest priority over all transfers):
  - Next state EMPTY: OUT_VALID=0, OUT_CTRL=0, OCC=0; IN_READY=1 next cycle.
  - An accept in the same cycle is completed upstream but discarded.
  - A consume in the same cycle is honoured by downstream; the stage still empties.
- Held output is stable: while OUT_VALID=1 & OUT_READY=0, OUT_DATA/OUT_CTRL must not change.
- OCC is registered and consistent with the state in the same cycle.

Test Plan:
- Reset mid-stream: SKID=1, hold OUT_READY=0, push 0x11 and 0x22 (OCC=2), then pulse RESET_N=0 between clock edges → OUT_VALID=0, OUT_CTRL=0, OCC=0 and IN_READY=1 immediately, without waiting for a clock edge.
- Streaming: OUT_READY=1, drive IN_DATA=1..8 with IN_VALID=1 for 8 cycles → OUT_DATA 1..8 in order, one cycle delayed, OCC=1 throughout, IN_READY constantly 1.
- Backpressure/skid: SKID=1, push 0xA then 0xB while OUT_READY=0 → OCC=2 and IN_READY=0 on the cycle after 0xB. Release OUT_READY → 0xA then 0xB on consecutive cycles, OCC 2→1→0.
- Flush: OCC=2 with IN_CTRL=7'h7F entries, assert FLUSH together with IN_VALID=1 (data 0xC) → next cycle OUT_VALID=0, OUT_CTRL=0, OCC=0; 0xC never appears at the output.
- SKID=0 stall: OUT_VALID=1 and OUT_READY=0 → IN_READY=0 combinationally and OUT_DATA stable for 5 cycles. Raise OUT_READY with IN_VALID=1 → IN_READY=1 in the same cycle and the new entry appears next cycle.
- Random: 10k cycles of random IN_VALID/OUT_READY/FLUSH (5%) for both SKID values, compared against a queue model → no loss, duplication or reorder except on flush, and OUT_CTRL=0 whenever OUT_VALID=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, synchronous flush,
// bubble zeroing of control bits and an optional 2-entry skid buffer.
module pipe_stage_reg #(
  parameter int DATA_W = 69,
  parameter int CTRL_W = 7,
  parameter int SKID   = 1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic [CTRL_W-1:0] IN_CTRL,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [CTRL_W-1:0] OUT_CTRL,
  output logic [1:0]        OCC
);

  // Handshake: an entry moves across a boundary on a rising CLK edge exactly
  // when both valid and ready are high there (accept upstream, consume downstream).
  // The encoding equals the occupancy, so OCC is the state register itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t            state;
  logic              in_ready_q;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              out_valid;
  logic              accept;
  logic              consume;

  assign out_valid = (state != ST_EMPTY);

  // With the skid buffer, ready is a flop so no combinational path reaches upstream.
  assign IN_READY  = (SKID != 0) ? in_ready_q : (!out_valid || OUT_READY);
  assign accept    = IN_VALID && IN_READY;
  assign consume   = out_valid && OUT_READY;

  assign OUT_VALID = out_valid;
  assign OUT_DATA  = main_data;
  assign OUT_CTRL  = main_ctrl;
  assign OCC       = state;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_data  <= '0;
      main_ctrl  <= '0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
    end else if (FLUSH) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_ctrl  <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state     <= ST_FULL;
            main_data <= IN_DATA;
            main_ctrl <= IN_CTRL;
          end
        end
        ST_FULL: begin
          if (accept && consume) begin
            main_data <= IN_DATA;
            main_ctrl <= IN_CTRL;
          end else if (accept && (SKID != 0)) begin
            // Downstream stalled while ready was still high: park in the skid slot.
            state      <= ST_SKID;
            in_ready_q <= 1'b0;
            skid_data  <= IN_DATA;
            skid_ctrl  <= IN_CTRL;
          end else if (consume) begin
            state     <= ST_EMPTY;
            main_ctrl <= '0;
          end
        end
        ST_SKID: begin
          if (consume) begin
            state      <= ST_FULL;
            in_ready_q <= 1'b1;
            main_data  <= skid_data;
            main_ctrl  <= skid_ctrl;
          end
        end
        default: begin
          state      <= ST_EMPTY;
          in_ready_q <= 1'b1;
          main_ctrl  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: both SKID variants share one stimulus stream, each
// checked against directed vectors and a queue-based reference model.
module tb_pipe_stage_reg;

  localparam int DATA_W = 69;
  localparam int CTRL_W = 7;
  localparam int W      = DATA_W + CTRL_W;

  logic              CLK = 1'b0;
  logic              RESET_N = 1'b1;
  logic              FLUSH = 1'b0;
  logic              IN_VALID = 1'b0;
  logic [DATA_W-1:0] IN_DATA = '0;
  logic [CTRL_W-1:0] IN_CTRL = '0;
  logic              OUT_READY = 1'b0;

  logic              s1_in_ready, s1_out_valid;
  logic [DATA_W-1:0] s1_out_data;
  logic [CTRL_W-1:0] s1_out_ctrl;
  logic [1:0]        s1_occ;
  logic              s0_in_ready, s0_out_valid;
  logic [DATA_W-1:0] s0_out_data;
  logic [CTRL_W-1:0] s0_out_ctrl;
  logic [1:0]        s0_occ;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q0[$];

  typedef struct {
    logic       in_valid;
    logic [7:0] in_data;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [6:0] exp_ctrl;
    logic [1:0] exp_occ;
  } vec_t;

  vec_t vecs[9];

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(1)) dut_s1 (
    .CLK(CLK), .RESET_N(RESET_N), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(s1_in_ready), .IN_DATA(IN_DATA), .IN_CTRL(IN_CTRL),
    .OUT_VALID(s1_out_valid), .OUT_READY(OUT_READY), .OUT_DATA(s1_out_data),
    .OUT_CTRL(s1_out_ctrl), .OCC(s1_occ)
  );

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(0)) dut_s0 (
    .CLK(CLK), .RESET_N(RESET_N), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(s0_in_ready), .IN_DATA(IN_DATA), .IN_CTRL(IN_CTRL),
    .OUT_VALID(s0_out_valid), .OUT_READY(OUT_READY), .OUT_DATA(s0_out_data),
    .OUT_CTRL(s0_out_ctrl), .OCC(s0_occ)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  task automatic reset_dut();
    IN_VALID = 1'b0; OUT_READY = 1'b0; FLUSH = 1'b0;
    #1 RESET_N = 1'b0;
    #1 RESET_N = 1'b1;
  endtask

  // Scoreboard compare
  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver: hold inputs across one rising edge, return 2 time units after it.
  task automatic cyc(input logic v, input logic [7:0] d, input logic [6:0] c,
                     input logic r, input logic f);
    IN_VALID = v; IN_DATA = DATA_W'(d); IN_CTRL = c; OUT_READY = r; FLUSH = f;
    @(posedge CLK);
    #2;
  endtask

  task automatic check_s1(input string tag, input logic v, input logic [7:0] d,
                          input logic [6:0] c, input logic [1:0] o, input logic r);
    check({tag, " s1 valid"}, 80'(s1_out_valid), 80'(v));
    if (v) check({tag, " s1 data"}, 80'(s1_out_data), 80'(d));
    check({tag, " s1 ctrl"}, 80'(s1_out_ctrl), 80'(c));
    check({tag, " s1 occ"}, 80'(s1_occ), 80'(o));
    check({tag, " s1 ready"}, 80'(s1_in_ready), 80'(r));
  endtask

  task automatic check_s0(input string tag, input logic v, input logic [7:0] d,
                          input logic [6:0] c, input logic [1:0] o, input logic r);
    check({tag, " s0 valid"}, 80'(s0_out_valid), 80'(v));
    if (v) check({tag, " s0 data"}, 80'(s0_out_data), 80'(d));
    check({tag, " s0 ctrl"}, 80'(s0_out_ctrl), 80'(c));
    check({tag, " s0 occ"}, 80'(s0_occ), 80'(o));
    check({tag, " s0 ready"}, 80'(s0_in_ready), 80'(r));
  endtask

  initial begin
    logic [95:0] rnd;
    logic        acc1, con1, acc0, con0, rdy1, rdy0, fl;

    for (int k = 0; k < 8; k++) begin
      vecs[k].in_valid  = 1'b1;
      vecs[k].in_data   = 8'(k + 1);
      vecs[k].exp_valid = 1'b1;
      vecs[k].exp_data  = 8'(k + 1);
      vecs[k].exp_ctrl  = 7'h55;
      vecs[k].exp_occ   = 2'd1;
    end
    vecs[8].in_valid  = 1'b0;
    vecs[8].in_data   = 8'h00;
    vecs[8].exp_valid = 1'b0;
    vecs[8].exp_data  = 8'h00;
    vecs[8].exp_ctrl  = 7'h00;
    vecs[8].exp_occ   = 2'd0;

    // Power-on reset, checked before any clock edge
    #1 RESET_N = 1'b0;
    #1;
    check_s1("por", 1'b0, 8'h00, 7'h00, 2'd0, 1'b1);
    check("por s1 data zero", 80'(s1_out_data), 80'h0);
    check_s0("por", 1'b0, 8'h00, 7'h00, 2'd0, 1'b1);
    repeat (2) @(posedge CLK);
    #2 RESET_N = 1'b1;

    // Reset in the middle of a stalled stream
    reset_dut();
    cyc(1'b1, 8'h11, 7'h7f, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 7'h7f, 1'b0, 1'b0);
    check_s1("pre-reset", 1'b1, 8'h11, 7'h7f, 2'd2, 1'b0);
    IN_VALID = 1'b0;
    #1 RESET_N = 1'b0;
    #1;
    check_s1("async reset", 1'b0, 8'h00, 7'h00, 2'd0, 1'b1);
    check("async reset s1 data zero", 80'(s1_out_data), 80'h0);
    RESET_N = 1'b1;

    // Streaming, table-driven, both variants
    reset_dut();
    for (int i = 0; i < 9; i++) begin
      cyc(vecs[i].in_valid, vecs[i].in_data, 7'h55, 1'b1, 1'b0);
      check_s1($sformatf("stream[%0d]", i), vecs[i].exp_valid, vecs[i].exp_data,
               vecs[i].exp_ctrl, vecs[i].exp_occ, 1'b1);
      check_s0($sformatf("stream[%0d]", i), vecs[i].exp_valid, vecs[i].exp_data,
               vecs[i].exp_ctrl, vecs[i].exp_occ, 1'b1);
    end

    // Backpressure into the skid slot, then drain
    reset_dut();
    cyc(1'b1, 8'h0a, 7'h0a, 1'b0, 1'b0);
    check_s1("skid push A", 1'b1, 8'h0a, 7'h0a, 2'd1, 1'b1);
    cyc(1'b1, 8'h0b, 7'h0b, 1'b0, 1'b0);
    check_s1("skid push B", 1'b1, 8'h0a, 7'h0a, 2'd2, 1'b0);
    cyc(1'b0, 8'h00, 7'h00, 1'b1, 1'b0);
    check_s1("skid drain 1", 1'b1, 8'h0b, 7'h0b, 2'd1, 1'b1);
    cyc(1'b0, 8'h00, 7'h00, 1'b1, 1'b0);
    check_s1("skid drain 2", 1'b0, 8'h00, 7'h00, 2'd0, 1'b1);

    // Flush from OCC=2, and flush racing a real accept
    reset_dut();
    cyc(1'b1, 8'h01, 7'h7f, 1'b0, 1'b0);
    cyc(1'b1, 8'h02, 7'h7f, 1'b0, 1'b0);
    check("flush pre s1 occ", 80'(s1_occ), 80'd2);
    cyc(1'b1, 8'h0c, 7'h7f, 1'b0, 1'b1);
    check_s1("flush full", 1'b0, 8'h00, 7'h00, 2'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'h00, 7'h00, 1'b1, 1'b0);
      check_s1($sformatf("flush after[%0d]", i), 1'b0, 8'h00, 7'h00, 2'd0, 1'b1);
    end
    cyc(1'b1, 8'h03, 7'h7f, 1'b0, 1'b0);
    check_s1("flush single pre", 1'b1, 8'h03, 7'h7f, 2'd1, 1'b1);
    cyc(1'b1, 8'h0d, 7'h7f, 1'b1, 1'b1);
    check_s1("flush with accept", 1'b0, 8'h00, 7'h00, 2'd0, 1'b1);
    cyc(1'b0, 8'h00, 7'h00, 1'b1, 1'b0);
    check_s1("flush accept dropped", 1'b0, 8'h00, 7'h00, 2'd0, 1'b1);

    // SKID=0 stall: combinational ready, stable held output
    reset_dut();
    cyc(1'b1, 8'h0e, 7'h0e, 1'b0, 1'b0);
    check_s0("stall load", 1'b1, 8'h0e, 7'h0e, 2'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 8'h0f, 7'h0f, 1'b0, 1'b0);
      check_s0($sformatf("stall hold[%0d]", i), 1'b1, 8'h0e, 7'h0e, 2'd1, 1'b0);
    end
    OUT_READY = 1'b1;
    #1;
    check("stall release s0 ready", 80'(s0_in_ready), 80'd1);
    @(posedge CLK);
    #1;
    check_s0("stall next", 1'b1, 8'h0f, 7'h0f, 2'd1, 1'b1);

    // Random traffic against queue models
    reset_dut();
    exp_q1.delete();
    exp_q0.delete();
    for (int n = 0; n < 10000; n++) begin
      rnd       = {$urandom(), $urandom(), $urandom()};
      IN_VALID  = ($urandom_range(0, 3) != 0);
      OUT_READY = ($urandom_range(0, 3) != 0);
      FLUSH     = ($urandom_range(0, 99) < 5);
      IN_DATA   = rnd[DATA_W-1:0];
      IN_CTRL   = CTRL_W'($urandom_range(0, 127));
      #1;
      rdy1 = (exp_q1.size() < 2);
      rdy0 = (exp_q0.size() == 0) || OUT_READY;
      check("rnd s1 ready", 80'(s1_in_ready), 80'(rdy1));
      check("rnd s0 ready", 80'(s0_in_ready), 80'(rdy0));
      check("rnd s1 occ", 80'(s1_occ), 80'(exp_q1.size()));
      check("rnd s0 occ", 80'(s0_occ), 80'(exp_q0.size()));
      if (exp_q1.size() > 0) check("rnd s1 entry", 80'({s1_out_valid, s1_out_ctrl, s1_out_data}),
                                   80'({1'b1, exp_q1[0]}));
      else check("rnd s1 bubble", 80'({s1_out_valid, s1_out_ctrl}), 80'd0);
      if (exp_q0.size() > 0) check("rnd s0 entry", 80'({s0_out_valid, s0_out_ctrl, s0_out_data}),
                                   80'({1'b1, exp_q0[0]}));
      else check("rnd s0 bubble", 80'({s0_out_valid, s0_out_ctrl}), 80'd0);
      acc1 = IN_VALID && rdy1;
      con1 = (exp_q1.size() > 0) && OUT_READY;
      acc0 = IN_VALID && rdy0;
      con0 = (exp_q0.size() > 0) && OUT_READY;
      fl   = FLUSH;
      @(posedge CLK);
      if (fl) begin
        exp_q1.delete();
        exp_q0.delete();
      end else begin
        if (con1) void'(exp_q1.pop_front());
        if (acc1) exp_q1.push_back({IN_CTRL, IN_DATA});
        if (con0) void'(exp_q0.pop_front());
        if (acc0) exp_q0.push_back({IN_CTRL, IN_DATA});
      end
      #2;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
